alu_decode: RTL and testbench
=============================

ALU_DECODE -- requirements
Module: alu_decode

Interface
REQ-001 SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port i_flush, input, 1, synchronous pipeline flush.
REQ-004 SHALL have ports i_valid (input, 1, instruction offered), o_in_ready (output, 1, decoder can accept), i_instr (input, 32, RV32I word) and i_pc (input, DATA_SIZE, instruction address).
REQ-005 SHALL have ports o_valid (output, 1, decoded entry present) and i_out_ready (input, 1, ALU stage consumes).
REQ-006 SHALL have ports o_funct (output, t_aluop, ALU operation), o_rs1_addr, o_rs2_addr and o_rd_addr (output, 5 each), o_imm (output, DATA_SIZE, sign-extended immediate), o_use_imm (output, 1, operand B is o_imm), o_use_pc (output, 1, operand A is o_pc), o_rd_we (output, 1, writeback enable), o_illegal (output, 1, unsupported encoding) and o_pc (output, DATA_SIZE, passed-through PC).

Function
REQ-007 SHALL accept an instruction on any edge where i_valid and o_in_ready are both 1; its decode SHALL appear on the outputs with o_valid=1 one cycle later.
REQ-008 SHALL retire the output entry on any edge where o_valid and i_out_ready are both 1.
REQ-009 SHALL hold all outputs stable while o_valid=1 and i_out_ready=0.
REQ-010 SHALL decode opcode 0110011 (OP) per funct3/funct7: 000/0000000 ADD, 000/0100000 SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101/0000000 SRL, 101/0100000 SRA, 110 OR, 111 AND; o_use_imm=0.
REQ-011 SHALL decode opcode 0010011 (OP-IMM) to the same functs without SUB, with o_use_imm=1 and o_imm the sign-extended I-immediate; for shifts o_imm SHALL equal the zero-extended shamt, and funct7 SHALL be 0000000 (SLLI/SRLI) or 0100000 (SRAI).
REQ-012 SHALL decode LUI as ADD with o_rs1_addr=0, o_use_imm=1 and o_imm={instr[31:12],12'b0}, and AUIPC identically except o_use_pc=1.
REQ-013 SHALL drive o_rd_we=1 for legal encodings with rd!=0, and 0 otherwise.
REQ-014 SHALL, for any other opcode or funct7 combination, emit o_valid with o_illegal=1, o_funct=ADD, o_rd_we=0 and o_imm=0; illegal entries SHALL NOT stall the handshake.
REQ-015 SHALL on i_flush=1 empty all stored entries at the next edge, drive o_in_ready=0 during that cycle and discard any input offered in that cycle; flush SHALL take priority over simultaneous accept and retire.
REQ-016 SHALL accept and retire on the same edge without a bubble when the output entry is full and i_out_ready=1.

Reset
REQ-017 SHALL asynchronously clear o_valid, o_illegal, o_rd_we, o_use_imm and o_use_pc to 0, o_funct to ADD, and all address, immediate and PC outputs to 0 while i_rst_n=0.
REQ-018 SHALL drive o_in_ready=0 during reset, and SHALL discard any entry in flight when reset asserts mid-transfer.

Configuration
REQ-019 SHALL, when ALU_DECODE_SKID_EN is defined, contain a second skid register, drive o_in_ready from a flop (=!skid_full), and sustain one instruction per cycle under single-cycle i_out_ready stalls, with skid contents presented in order before new input.
REQ-020 SHALL, without ALU_DECODE_SKID_EN, hold a single entry and drive o_in_ready = !o_valid || i_out_ready combinationally.

Structure
REQ-021 SHALL take t_aluop and DATA_SIZE from multicore_pkg, and SHALL add opcode constants (OP, OP_IMM, LUI, AUIPC) and a t_decoded struct for the registered payload to that package.
REQ-022 SHALL place the combinational instruction-to-t_decoded mapping in a sub-module alu_funct_decode, with alu_decode owning only the handshake and the registers.

Verification
REQ-023 Bench SHALL drive 0x002081B3 (add x3,x1,x2) -> after 1 cycle: o_funct=ADD, rs1=1, rs2=2, rd=3, o_use_imm=0, o_rd_we=1.
REQ-024 Bench SHALL drive 0x40335293 (srai x5,x6,3) -> o_funct=SRA, o_imm=3, o_use_imm=1; and 0xFFF00093 (addi x1,x0,-1) -> o_imm=0xFFFFFFFF.
REQ-025 Bench SHALL drive 0x123453B7 (lui x7) -> ADD, o_rs1_addr=0, o_imm=0x12345000; and the same word with opcode 0010111 (auipc) -> additionally o_use_pc=1.
REQ-026 Bench SHALL drive 0x00000000 and 0x0000006F -> o_valid=1, o_illegal=1, o_rd_we=0.
REQ-027 Bench SHALL stream 8 instructions against i_out_ready toggling 1,0,1,0 -> all 8 retired in order with no duplicates; with ALU_DECODE_SKID_EN, o_in_ready stays 1 throughout.
REQ-028 Bench SHALL assert i_flush with an entry full and i_valid=1 -> o_valid=0 on the next cycle and no entry retires; it SHALL also assert i_rst_n=0 mid-stall -> o_valid=0 immediately.

Source files
------------

// File: rtl/multicore_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multicore_pkg : shared ALU op encoding, RV32I opcodes, decoded entry |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package multicore_pkg;

  localparam int DATA_SIZE = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } t_aluop;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef struct packed {
    t_aluop                 funct;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             rd;
    logic [DATA_SIZE-1:0]   imm;
    logic                   use_imm;
    logic                   use_pc;
    logic                   rd_we;
    logic                   illegal;
    logic [DATA_SIZE-1:0]   pc;
  } t_decoded;

  localparam t_decoded DEC_RESET = '{
    funct: ALU_ADD, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, imm: '0,
    use_imm: 1'b0, use_pc: 1'b0, rd_we: 1'b0, illegal: 1'b0, pc: '0
  };

  // alt selects the funct7[5] variant (SUB / SRA)
  function automatic t_aluop base_funct(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_funct_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_funct_decode : combinational RV32I word -> t_decoded mapping     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module alu_funct_decode
  import multicore_pkg::*;
(
  input  logic [31:0]          i_instr,
  input  logic [DATA_SIZE-1:0] i_pc,
  output t_decoded             o_dec
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       is_shift;
  logic       legal;
  t_decoded   dec;

  assign opcode   = i_instr[6:0];
  assign funct3   = i_instr[14:12];
  assign funct7   = i_instr[31:25];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    dec    = DEC_RESET;
    dec.pc = i_pc;
    legal  = 1'b1;
    case (opcode)
      OP: begin
        dec.rs1   = i_instr[19:15];
        dec.rs2   = i_instr[24:20];
        dec.rd    = i_instr[11:7];
        dec.funct = base_funct(funct3, funct7[5]);
        legal     = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OP_IMM: begin
        dec.rs1     = i_instr[19:15];
        dec.rd      = i_instr[11:7];
        dec.use_imm = 1'b1;
        if (is_shift) begin
          // Shifts carry shamt in the immediate field; funct7 picks SRL vs SRA.
          dec.funct = base_funct(funct3, funct7[5]);
          dec.imm   = {{(DATA_SIZE-5){1'b0}}, i_instr[24:20]};
          legal     = (funct7 == 7'b0000000) ||
                      ((funct3 == 3'b101) && (funct7 == 7'b0100000));
        end else begin
          dec.funct = base_funct(funct3, 1'b0);
          dec.imm   = {{(DATA_SIZE-12){i_instr[31]}}, i_instr[31:20]};
        end
      end
      LUI, AUIPC: begin
        dec.rd      = i_instr[11:7];
        dec.use_imm = 1'b1;
        dec.use_pc  = (opcode == AUIPC);
        dec.imm     = DATA_SIZE'({i_instr[31:12], 12'b0});
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      dec         = DEC_RESET;
      dec.pc      = i_pc;
      dec.illegal = 1'b1;
    end
    dec.rd_we = legal && (dec.rd != 5'd0);
  end

  assign o_dec = dec;

endmodule
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_decode : registered RV32I ALU decode stage with valid/ready      |
// | Optional skid register when ALU_DECODE_SKID_EN is defined. rev 1.0   |
// +----------------------------------------------------------------------+
module alu_decode
  import multicore_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_flush,
  input  logic                 i_valid,
  output logic                 o_in_ready,
  input  logic [31:0]          i_instr,
  input  logic [DATA_SIZE-1:0] i_pc,
  output logic                 o_valid,
  input  logic                 i_out_ready,
  output t_aluop               o_funct,
  output logic [4:0]           o_rs1_addr,
  output logic [4:0]           o_rs2_addr,
  output logic [4:0]           o_rd_addr,
  output logic [DATA_SIZE-1:0] o_imm,
  output logic                 o_use_imm,
  output logic                 o_use_pc,
  output logic                 o_rd_we,
  output logic                 o_illegal,
  output logic [DATA_SIZE-1:0] o_pc
);

  t_decoded dec;
  t_decoded out_q, out_d;
  logic     valid_q, valid_d;
  logic     accept, retire;

  alu_funct_decode u_funct_decode (
    .i_instr (i_instr),
    .i_pc    (i_pc),
    .o_dec   (dec)
  );

  assign accept = i_valid && o_in_ready;
  assign retire = valid_q && i_out_ready;

`ifdef ALU_DECODE_SKID_EN
  t_decoded skid_q, skid_d;
  logic     skid_valid_q, skid_valid_d;
  logic     in_ready_q, in_ready_d;

  assign o_in_ready = i_rst_n && in_ready_q && !i_flush;

  always_comb begin
    out_d        = out_q;
    valid_d      = valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (i_flush) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!valid_q || retire) begin
      // Main slot frees up: older skid contents go first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        valid_d      = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        valid_d = accept;
        if (accept) out_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      skid_q       <= DEC_RESET;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign o_in_ready = i_rst_n && !i_flush && (!valid_q || i_out_ready);

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      out_d   = dec;
      valid_d = 1'b1;
    end else if (retire) begin
      valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q   <= DEC_RESET;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_funct    = out_q.funct;
  assign o_rs1_addr = out_q.rs1;
  assign o_rs2_addr = out_q.rs2;
  assign o_rd_addr  = out_q.rd;
  assign o_imm      = out_q.imm;
  assign o_use_imm  = out_q.use_imm;
  assign o_use_pc   = out_q.use_pc;
  assign o_rd_we    = out_q.rd_we;
  assign o_illegal  = out_q.illegal;
  assign o_pc       = out_q.pc;

endmodule
`default_nettype wire

// File: tb/tb_alu_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_decode : directed vectors against a queue-based decode model  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_alu_decode;
  import multicore_pkg::*;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic                 i_flush = 1'b0;
  logic                 i_valid = 1'b0;
  logic                 i_out_ready = 1'b0;
  logic [31:0]          i_instr = '0;
  logic [DATA_SIZE-1:0] i_pc = '0;
  logic                 o_in_ready, o_valid;
  t_aluop               o_funct;
  logic [4:0]           o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [DATA_SIZE-1:0] o_imm, o_pc;
  logic                 o_use_imm, o_use_pc, o_rd_we, o_illegal;

  alu_decode dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_valid     (i_valid),
    .o_in_ready  (o_in_ready),
    .i_instr     (i_instr),
    .i_pc        (i_pc),
    .o_valid     (o_valid),
    .i_out_ready (i_out_ready),
    .o_funct     (o_funct),
    .o_rs1_addr  (o_rs1_addr),
    .o_rs2_addr  (o_rs2_addr),
    .o_rd_addr   (o_rd_addr),
    .o_imm       (o_imm),
    .o_use_imm   (o_use_imm),
    .o_use_pc    (o_use_pc),
    .o_rd_we     (o_rd_we),
    .o_illegal   (o_illegal),
    .o_pc        (o_pc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    t_aluop      funct;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_imm;
    logic        use_pc;
    logic        rd_we;
    logic        illegal;
    logic [31:0] pc;
  } exp_t;

  localparam t_aluop BASE_OP [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam t_aluop ALT_OP  [8] = '{ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRA, ALU_OR, ALU_AND};

  int   errors = 0;
  int   checks = 0;
  int   dut_ret = 0;
  exp_t q[$];
  logic [31:0] pc = 32'h0000_1000;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference decode from the instruction-set rules, table-driven on funct3.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    logic [6:0] opc, f7;
    logic [2:0] f3;
    bit ok, shift;
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    e = '0; e.funct = ALU_ADD; e.pc = p; e.rd = w[11:7]; ok = 0;
    if (opc == 7'h33) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      e.funct = (f7 == 7'h20) ? ALT_OP[f3] : BASE_OP[f3];
      e.rs1 = w[19:15]; e.rs2 = w[24:20];
    end else if (opc == 7'h13) begin
      ok = !shift || (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
      e.funct = (shift && f7 == 7'h20) ? ALT_OP[f3] : BASE_OP[f3];
      e.rs1 = w[19:15]; e.use_imm = 1'b1;
      e.imm = shift ? {27'd0, w[24:20]} : {{20{w[31]}}, w[31:20]};
    end else if (opc == 7'h37 || opc == 7'h17) begin
      ok = 1; e.use_imm = 1'b1; e.use_pc = (opc == 7'h17);
      e.imm = {w[31:12], 12'd0};
    end
    if (!ok) begin
      e = '0; e.funct = ALU_ADD; e.pc = p; e.illegal = 1'b1;
    end else begin
      e.rd_we = (e.rd != 5'd0);
    end
    return e;
  endfunction

  function automatic bit exp_ready(input int n);
`ifdef ALU_DECODE_SKID_EN
    return !i_flush && (n < 2);
`else
    return !i_flush && (n == 0 || i_out_ready);
`endif
  endfunction

  // Model state: queue of entries held by the stage, oldest first.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q.delete();
    end else if (i_flush) begin
      q.delete();
    end else begin
      if (i_valid && exp_ready(q.size())) begin
        if (q.size() != 0 && i_out_ready) void'(q.pop_front());
        q.push_back(model(i_instr, i_pc));
      end else if (q.size() != 0 && i_out_ready) begin
        void'(q.pop_front());
      end
    end
  end

  always @(posedge i_clk) begin
    if (i_rst_n && !i_flush && o_valid && i_out_ready) dut_ret <= dut_ret + 1;
  end

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      chk("reset_outputs",
          {o_valid, o_in_ready, o_funct, o_rs1_addr, o_rs2_addr, o_rd_addr, o_imm,
           o_use_imm, o_use_pc, o_rd_we, o_illegal, o_pc}, '0);
    end else begin
      chk("o_valid", o_valid, q.size() != 0);
      chk("o_in_ready", o_in_ready, exp_ready(q.size()));
      if (q.size() != 0 && o_valid)
        chk("payload",
            {o_funct, o_rs1_addr, o_rs2_addr, o_rd_addr, o_imm,
             o_use_imm, o_use_pc, o_rd_we, o_illegal, o_pc}, q[0]);
    end
  end

  // Offer one word with the consumer ready; returns at the negedge it is on the outputs.
  task automatic send(input logic [31:0] w, input logic rdy);
    @(negedge i_clk); #1;
    i_valid = 1'b1; i_instr = w; i_pc = pc; i_out_ready = rdy;
    @(posedge i_clk); #1;
    i_valid = 1'b0; pc += 4;
    @(negedge i_clk);
  endtask

  task automatic drain();
    #1; i_valid = 1'b0; i_out_ready = 1'b1;
    repeat (3) @(negedge i_clk);
  endtask

  logic [31:0] stream [8] = '{32'h00100093, 32'h00208133, 32'h402081B3, 32'h0020C233,
                              32'h00309293, 32'hABCDE337, 32'h00000397, 32'hFFF0F413};

  initial begin
    int  idx, cyc, base;
    bit  took;
    repeat (3) @(negedge i_clk);
    chk("reset_in_ready", o_in_ready, 1'b0);
    #1 i_rst_n = 1'b1;

    send(32'h002081B3, 1'b1);
    chk("add_funct", o_funct, ALU_ADD);
    chk("add_regs", {o_rs1_addr, o_rs2_addr, o_rd_addr}, {5'd1, 5'd2, 5'd3});
    chk("add_flags", {o_valid, o_use_imm, o_rd_we, o_illegal}, 4'b1010);

    send(32'h40335293, 1'b1);
    chk("srai", {o_funct, o_imm, o_use_imm, o_rs1_addr, o_rd_addr}, {ALU_SRA, 32'd3, 1'b1, 5'd6, 5'd5});

    send(32'hFFF00093, 1'b1);
    chk("addi_m1", {o_funct, o_imm, o_use_imm}, {ALU_ADD, 32'hFFFF_FFFF, 1'b1});

    send(32'h123453B7, 1'b1);
    chk("lui", {o_funct, o_rs1_addr, o_imm, o_use_imm, o_use_pc, o_rd_addr},
        {ALU_ADD, 5'd0, 32'h1234_5000, 1'b1, 1'b0, 5'd7});

    send(32'h12345397, 1'b1);
    chk("auipc", {o_funct, o_rs1_addr, o_imm, o_use_imm, o_use_pc, o_rd_addr},
        {ALU_ADD, 5'd0, 32'h1234_5000, 1'b1, 1'b1, 5'd7});

    send(32'h00000000, 1'b1);
    chk("illegal_zero", {o_valid, o_illegal, o_rd_we, o_funct, o_imm}, {3'b110, ALU_ADD, 32'd0});

    send(32'h0000006F, 1'b1);
    chk("illegal_jal", {o_valid, o_illegal, o_rd_we, o_funct, o_imm}, {3'b110, ALU_ADD, 32'd0});

    send(32'h022081B3, 1'b1);
    chk("illegal_f7", {o_valid, o_illegal, o_rd_we}, 3'b110);

    send(32'h40209093, 1'b1);
    chk("illegal_slli", {o_valid, o_illegal, o_rd_we}, 3'b110);

    send(32'h00000013, 1'b1);
    chk("nop_rd0", {o_valid, o_illegal, o_rd_we}, 3'b100);

    drain();

    // Eight-word stream against a consumer that is ready every other cycle.
    base = dut_ret; idx = 0; cyc = 0;
    while (idx < 8 && cyc < 64) begin
      @(negedge i_clk); #1;
      i_out_ready = (cyc % 2 == 0);
      i_valid = 1'b1; i_instr = stream[idx]; i_pc = pc;
      #1 took = o_in_ready;
      @(posedge i_clk);
      if (took) begin idx++; pc += 4; end
      cyc++;
    end
    #1; i_valid = 1'b0; i_out_ready = 1'b1;
    cyc = 0;
    while ((q.size() != 0 || o_valid) && cyc < 20) begin
      @(negedge i_clk); cyc++;
    end
    @(negedge i_clk);
    chk("stream_accepted", idx, 8);
    chk("stream_retired", dut_ret - base, 8);

    // Flush with an entry held and a new word offered in the same cycle.
    send(32'h00500313, 1'b0);
    chk("flush_pre_valid", o_valid, 1'b1);
    #1; i_flush = 1'b1; i_valid = 1'b1; i_instr = 32'h00600393; i_out_ready = 1'b1;
    #1 chk("flush_in_ready", o_in_ready, 1'b0);
    base = dut_ret;
    @(posedge i_clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    @(negedge i_clk);
    chk("flush_valid", o_valid, 1'b0);
    chk("flush_no_retire", dut_ret - base, 0);

    // Reset asserted while the output is stalled.
    send(32'h00700413, 1'b0);
    chk("rst_pre_valid", o_valid, 1'b1);
    #1 i_rst_n = 1'b0;
    #1;
    chk("rst_async_valid", o_valid, 1'b0);
    chk("rst_async_ready", o_in_ready, 1'b0);
    chk("rst_async_payload", {o_rd_we, o_imm, o_rd_addr, o_pc}, '0);
    repeat (2) @(negedge i_clk);
    #1 i_rst_n = 1'b1;

    send(32'hFFF00093, 1'b1);
    chk("post_rst_imm", {o_valid, o_imm}, {1'b1, 32'hFFFF_FFFF});
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
